// File: rtl/wisard_scorer_par.sv
// Parallel-lane WiSARD scorer: per-class popcount accumulation, end-of-frame snapshot, sequential argmax.
// Optional build macro WISARD_MARGIN_EN adds a margin output (best minus second-best score).
//
// state  | meaning
// IDLE   | waiting for an accepted eop beat to start a search
// SEARCH | scanning snapshot one class per cycle, index k = 0..N_CLASSES-1
// DONE   | result ready; waits for the output register to be free
module wisard_scorer_par #(
    parameter int N_CLASSES   = 10,
    parameter int CLASS_WIDTH = 4,
    parameter int LANES       = 4,
    parameter int COUNT_WIDTH = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sink_valid,
    output logic                         sink_ready,
    input  logic                         sop,
    input  logic                         eop,
    input  logic [LANES*N_CLASSES-1:0]   hits,
    input  logic [LANES-1:0]             lane_en,
    output logic                         source_valid,
    input  logic                         source_ready,
    output logic [CLASS_WIDTH-1:0]       class_result,
    output logic [COUNT_WIDTH-1:0]       max_score,
    output logic                         tie
`ifdef WISARD_MARGIN_EN
    ,
    output logic [COUNT_WIDTH-1:0]       margin
`endif
);

    localparam int INC_W = $clog2(LANES + 1);
    localparam logic [COUNT_WIDTH-1:0] SAT    = '1;
    localparam logic [CLASS_WIDTH-1:0] LAST_K = CLASS_WIDTH'(N_CLASSES - 1);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t                 state, state_nxt;
    logic                   accept;
    logic                   search_step;
    logic                   load_result;
    logic [INC_W-1:0]       inc      [N_CLASSES];
    logic [COUNT_WIDTH:0]   sum      [N_CLASSES];
    logic [COUNT_WIDTH-1:0] cnt      [N_CLASSES];
    logic [COUNT_WIDTH-1:0] cnt_nxt  [N_CLASSES];
    logic [COUNT_WIDTH-1:0] snap     [N_CLASSES];
    logic                   snap_valid;
    logic [CLASS_WIDTH-1:0] k;
    logic [COUNT_WIDTH-1:0] best;
    logic [CLASS_WIDTH-1:0] best_idx;
    logic                   best_tie;
`ifdef WISARD_MARGIN_EN
    logic [COUNT_WIDTH-1:0] second;
`endif

    assign sink_ready = ~snap_valid;
    assign accept     = sink_valid & sink_ready;

    always_comb begin
        for (int j = 0; j < N_CLASSES; j++) begin
            inc[j] = '0;
            for (int l = 0; l < LANES; l++)
                inc[j] = inc[j] + INC_W'(hits[l*N_CLASSES+j] & lane_en[l]);
        end
    end

    // One extra bit on the sum detects overflow so the counter clamps instead of wrapping.
    always_comb begin
        for (int j = 0; j < N_CLASSES; j++) begin
            sum[j] = (sop ? {(COUNT_WIDTH+1){1'b0}} : {1'b0, cnt[j]})
                   + {{(COUNT_WIDTH+1-INC_W){1'b0}}, inc[j]};
            cnt_nxt[j] = sum[j][COUNT_WIDTH] ? SAT : sum[j][COUNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < N_CLASSES; j++) begin
                cnt[j]  <= '0;
                snap[j] <= '0;
            end
            snap_valid <= 1'b0;
        end else if (accept) begin
            for (int j = 0; j < N_CLASSES; j++)
                cnt[j] <= cnt_nxt[j];
            if (eop) begin
                for (int j = 0; j < N_CLASSES; j++)
                    snap[j] <= cnt_nxt[j];
                snap_valid <= 1'b1;
            end
        end else if (load_result) begin
            snap_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        search_step = 1'b0;
        load_result = 1'b0;
        case (state)
            IDLE: begin
                if (accept && eop)
                    state_nxt = SEARCH;
            end
            SEARCH: begin
                search_step = 1'b1;
                if (k == LAST_K)
                    state_nxt = DONE;
            end
            DONE: begin
                if (!source_valid || source_ready) begin
                    load_result = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strict greater-than keeps the lowest index on equal scores.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k        <= '0;
            best     <= '0;
            best_idx <= '0;
            best_tie <= 1'b0;
`ifdef WISARD_MARGIN_EN
            second   <= '0;
`endif
        end else if (search_step) begin
            k <= (k == LAST_K) ? '0 : k + CLASS_WIDTH'(1);
            if (k == '0) begin
                best     <= snap[k];
                best_idx <= '0;
                best_tie <= 1'b0;
`ifdef WISARD_MARGIN_EN
                second   <= '0;
`endif
            end else if (snap[k] > best) begin
                best     <= snap[k];
                best_idx <= k;
                best_tie <= 1'b0;
`ifdef WISARD_MARGIN_EN
                second   <= best;
`endif
            end else if (snap[k] == best) begin
                best_tie <= 1'b1;
`ifdef WISARD_MARGIN_EN
                second   <= best;
`endif
            end else begin
`ifdef WISARD_MARGIN_EN
                if (snap[k] > second)
                    second <= snap[k];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            source_valid <= 1'b0;
            class_result <= '0;
            max_score    <= '0;
            tie          <= 1'b0;
`ifdef WISARD_MARGIN_EN
            margin       <= '0;
`endif
        end else if (load_result) begin
            source_valid <= 1'b1;
            class_result <= best_idx;
            max_score    <= best;
            tie          <= best_tie;
`ifdef WISARD_MARGIN_EN
            margin       <= best - second;
`endif
        end else if (source_ready) begin
            source_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wisard_scorer_par.sv
// Randomized bench for wisard_scorer_par against a frame-level score model with an expected-result queue.
module tb_wisard_scorer_par;

    localparam int NC   = 10;
    localparam int CW   = 4;
    localparam int LN   = 4;
    localparam int CNTW = 12;
    localparam int SATV = (1 << CNTW) - 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               sink_valid;
    logic               sink_ready;
    logic               sop;
    logic               eop;
    logic [LN*NC-1:0]   hits;
    logic [LN-1:0]      lane_en;
    logic               source_valid;
    logic               source_ready;
    logic [CW-1:0]      class_result;
    logic [CNTW-1:0]    max_score;
    logic               tie;
`ifdef WISARD_MARGIN_EN
    logic [CNTW-1:0]    margin;
`endif

    wisard_scorer_par #(
        .N_CLASSES(NC), .CLASS_WIDTH(CW), .LANES(LN), .COUNT_WIDTH(CNTW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sink_valid(sink_valid), .sink_ready(sink_ready),
        .sop(sop), .eop(eop), .hits(hits), .lane_en(lane_en),
        .source_valid(source_valid), .source_ready(source_ready),
        .class_result(class_result), .max_score(max_score), .tie(tie)
`ifdef WISARD_MARGIN_EN
        , .margin(margin)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int cls;
        int score;
        int tie;
        int margin;
    } res_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   mscore [NC];
    res_t exp_q [$];
    int   rdy_mode = 1;  // 0: hold off, 1: always ready, 2: random

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_beat(input bit s, input bit e, input logic [LN*NC-1:0] h,
                              input logic [LN-1:0] le);
        res_t r;
        int   second;
        int   nmax;
        for (int j = 0; j < NC; j++) begin
            int add = 0;
            for (int l = 0; l < LN; l++)
                if (h[l*NC+j] && le[l]) add++;
            mscore[j] = (s ? 0 : mscore[j]) + add;
            if (mscore[j] > SATV) mscore[j] = SATV;
        end
        if (e) begin
            r.score = -1;
            r.cls   = 0;
            for (int j = 0; j < NC; j++)
                if (mscore[j] > r.score) begin r.score = mscore[j]; r.cls = j; end
            nmax   = 0;
            second = 0;
            for (int j = 0; j < NC; j++) begin
                if (mscore[j] == r.score) nmax++;
                if (j != r.cls && mscore[j] > second) second = mscore[j];
            end
            r.tie    = (nmax > 1) ? 1 : 0;
            r.margin = r.score - second;
            exp_q.push_back(r);
        end
    endtask

    task automatic send_beat(input bit s, input bit e, input logic [LN*NC-1:0] h,
                             input logic [LN-1:0] le);
        int waitc = 0;
        sink_valid = 1'b1; sop = s; eop = e; hits = h; lane_en = le;
        while (!sink_ready && waitc < 300) begin
            @(negedge clk);
            waitc++;
        end
        if (!sink_ready) begin
            check("sink_ready_timeout", sink_ready, 1);
            sink_valid = 1'b0;
            return;
        end
        model_beat(s, e, h, le);
        @(negedge clk);
        sink_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            sink_valid = 1'b0;
            sop  = 1'($urandom_range(0, 1));
            eop  = 1'($urandom_range(0, 1));
            hits = LN*NC'({$urandom, $urandom});
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int waitc = 0;
        while ((exp_q.size() != 0 || source_valid) && waitc < 400) begin
            @(negedge clk);
            waitc++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    function automatic logic [LN*NC-1:0] rand_hits();
        logic [63:0] t = {$urandom, $urandom};
        return t[LN*NC-1:0];
    endfunction

    // Output monitor: predicts the handshake it grants and checks stability while held.
    initial begin
        bit            held = 0;
        logic [CW-1:0] h_cls;
        logic [CNTW-1:0] h_score;
        logic          h_tie;
        res_t          r;
        source_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (held && rst_n) begin
                check("hold_valid", source_valid, 1);
                check("hold_class", class_result, h_cls);
                check("hold_score", max_score, h_score);
                check("hold_tie", tie, h_tie);
            end
            held = 0;
            case (rdy_mode)
                0:       source_ready = 1'b0;
                1:       source_ready = 1'b1;
                default: source_ready = 1'($urandom_range(0, 1));
            endcase
            if (source_valid && source_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", exp_q.size(), 1);
                end else begin
                    r = exp_q.pop_front();
                    check("class_result", class_result, r.cls);
                    check("max_score", max_score, r.score);
                    check("tie", tie, r.tie);
`ifdef WISARD_MARGIN_EN
                    check("margin", margin, r.margin);
`endif
                end
            end else if (source_valid) begin
                held    = 1;
                h_cls   = class_result;
                h_score = max_score;
                h_tie   = tie;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LN*NC-1:0] h;
        int               lat;
        int               nb;
        rst_n = 1'b0; sink_valid = 1'b0; sop = 1'b0; eop = 1'b0;
        hits = '0; lane_en = '0;
        for (int j = 0; j < NC; j++) mscore[j] = 0;
        repeat (3) @(negedge clk);
        check("rst_source_valid", source_valid, 0);
        check("rst_class_result", class_result, 0);
        check("rst_max_score", max_score, 0);
        check("rst_tie", tie, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_sink_ready", sink_ready, 1);

        // single-beat frame: class 3 on all lanes, class 7 on two lanes
        rdy_mode = 1;
        h = '0;
        for (int l = 0; l < LN; l++) h[l*NC+3] = 1'b1;
        h[0*NC+7] = 1'b1;
        h[2*NC+7] = 1'b1;
        send_beat(1, 1, h, 4'b1111);
        check("sink_stall_after_eop", sink_ready, 0);
        lat = 0;
        while (!source_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == NC) check("sink_stall_search", sink_ready, 0);
        end
        check("result_latency", lat, NC + 1);
        check("sink_ready_release", sink_ready, 1);
        check("single_class", class_result, 3);
        check("single_score", max_score, 4);
        drain();

        // 3-beat tie between classes 2 and 5
        for (int b = 0; b < 3; b++) begin
            h = '0;
            h[$urandom_range(0, LN-1)*NC+5] = 1'b1;
            h[$urandom_range(0, LN-1)*NC+2] = 1'b1;
            send_beat(b == 0, b == 2, h, 4'b1111);
        end
        drain();

        // only lane 0 enabled, all hits set: every class ties at 5
        h = '1;
        for (int b = 0; b < 5; b++) send_beat(b == 0, b == 4, h, 4'b0001);
        drain();
        send_beat(1, 0, h, 4'b0000);
        send_beat(0, 1, h, 4'b0000);
        drain();

        // saturation: class 1 on every lane, class 4 on three lanes
        h = '0;
        for (int l = 0; l < LN; l++) h[l*NC+1] = 1'b1;
        for (int l = 0; l < 3; l++) h[l*NC+4] = 1'b1;
        for (int b = 0; b < 1030; b++) send_beat(b == 0, b == 1029, h, 4'b1111);
        drain();

        // back-to-back frames with the sink holding off
        rdy_mode = 0;
        @(negedge clk);
        send_beat(1, 0, rand_hits(), 4'b1111);
        send_beat(0, 1, rand_hits(), 4'b1011);
        send_beat(1, 1, rand_hits(), 4'b1111);
        repeat (25) @(negedge clk);
        check("b2b_sink_stall", sink_ready, 0);
        check("b2b_source_valid", source_valid, 1);
        check("b2b_queue_depth", exp_q.size(), 2);
        rdy_mode = 1;
        drain();

        // reset during search discards the frame and clears the counters
        send_beat(1, 1, rand_hits(), 4'b1111);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_source_valid", source_valid, 0);
        check("midrst_sink_ready", sink_ready, 1);
        check("midrst_max_score", max_score, 0);
        check("midrst_class", class_result, 0);
        rst_n = 1'b1;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        for (int j = 0; j < NC; j++) mscore[j] = 0;
        send_beat(0, 0, rand_hits(), 4'b1111);
        send_beat(0, 1, rand_hits(), 4'b0111);
        drain();

        // randomized frames with random gaps and random sink back-pressure
        rdy_mode = 2;
        for (int f = 0; f < 40; f++) begin
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                send_beat((b == 0) && ($urandom_range(0, 7) != 0), b == nb - 1,
                          rand_hits(), LN'($urandom));
                idle_cycles($urandom_range(0, 2));
            end
        end
        rdy_mode = 1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
